keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Upstream input stage for the tic-tac-toe game-state block. It scans the trainer's 3x4 matrix keypad, synchronizes and debounces the row inputs, and emits one clean key event per physical press. Each event is a 4-bit key_data code with a one-cycle key_valid strobe. The game-state stage consumes key_data 1..9 as board-cell selects on key_valid and never sees bounce, repeats or ghost keys.

Parameters:
SCAN_DIV, 25000, clk cycles per scan tick (1 kHz at 25 MHz); legal range >= 4.
DEBOUNCE_SCANS, 8, consecutive matching ticks required to accept a press, and consecutive all-zero ticks required to accept a release; legal range 2..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_row  in  4  keypad row sense, active-high, asynchronous to clk
key_col  out  3  keypad column drive, one-hot, active-high
key_data  out  4  code of last accepted key
key_valid  out  1  one-clk strobe; key_data is new this cycle
key_busy  out  1  high from press detection until release is accepted

Behaviour:
- Reset values: key_col=3'b001, key_data=4'h0, key_valid=0, key_busy=0, state=SCAN, tick and debounce counters=0. Reset is asserted asynchronously and released synchronously.
- key_row passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick: single-cycle pulse every SCAN_DIV clks; counter runs 0..SCAN_DIV-1 and wraps.
- Key code map, row r (0..3) x column c (0..2):
  - r0 gives 1, 2, 3; r1 gives 4, 5, 6; r2 gives 7, 8, 9.
  - r3 gives '*'=4'hA, '0'=4'h0, '#'=4'hB.
- State SCAN:
  - On tick, the synchronized row is sampled for the current column.
  - Exactly one row bit high: latch (row, col) as candidate, set match count=1, set key_busy=1, hold key_col, go to DEBOUNCE.
  - Zero bits or two or more bits high (ghost/multi-key): rotate key_col 001->010->100->001 and stay in SCAN.
- State DEBOUNCE, on each tick:
  - Row equals the candidate one-hot: increment the match count.
  - Any other row value: clear key_busy, rotate key_col, return to SCAN, emit no event.
  - When the match count reaches DEBOUNCE_SCANS: go to HELD. In the following clk cycle key_data=code and key_valid=1, for exactly one cycle.
- State HELD:
  - key_col stays frozen on the candidate column.
  - On each tick, row==0 increments the release count; any nonzero row clears it.
  - Release count reaching DEBOUNCE_SCANS: clear key_busy, rotate key_col, go to SCAN.
- Auto-repeat: none. A held key yields exactly one event. A second key pressed while in HELD is ignored, even after the first key is released, until release is accepted and the second key is re-detected in SCAN.
- key_data holds its value between events and is only valid to consumers when qualified by key_valid.
- Press latency: the event arrives after DEBOUNCE_SCANS ticks including the detection tick, plus 1 clk (register), plus 2 clks of synchronizer delay before the first tick can see the row.
- Reset mid-debounce or mid-HELD: return immediately to the reset values; no event is emitted.

Decomposition:
- Shared package game_pkg holds:
  - key code constants KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_ZERO=4'h0;
  - the scanner state encoding (SCAN, DEBOUNCE, HELD);
  - the default SCAN_DIV.
- One sub-module is natural: tick_gen (parameter DIV; ports clk, rst_n, tick). It is reusable by the 7-segment multiplexer in the game-state stage.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
1. Clean press of key 5: hold key_row=4'b0010 while key_col=010 for 20 ticks -> exactly one key_valid pulse with key_data=4'h5, and key_col frozen at 010 until release.
2. Bounce: toggle row bit 0 on column 001 every tick for 6 ticks, then hold it stable -> no event during the bounce; one event with key_data=4'h1 after 3 stable ticks.
3. Release debounce: after the key-9 event, drop the row for 2 ticks, reassert it for 1 tick, then drop it for 3 ticks -> no second event; key_busy falls only after the 3 consecutive zero ticks.
4. Multi-key: rows 4'b0011 on column 100 -> no event, key_col keeps rotating; then a single row 4'b1000 on 100 -> key_data=4'hB.
5. Reset mid-DEBOUNCE: assert rst_n=0 after 2 matching ticks -> asynchronous key_col=001, key_busy=0, key_valid=0; no event after release of reset.
6. Hand-over: press 7, then press 3 while 7 is still held, then release 7 and keep 3 held -> events are exactly 4'h7 then 4'h3, in that order.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe front end: key codes, scanner states
// and keypad geometry helpers.
package game_pkg;

  localparam int unsigned ROW_W            = 4;
  localparam int unsigned COL_W            = 3;
  localparam int unsigned CODE_W           = 4;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned SCAN_DIV_DEFAULT = 25000;

  localparam logic [CODE_W-1:0] KEY_STAR = 4'hA;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'hB;
  localparam logic [CODE_W-1:0] KEY_ZERO = 4'h0;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Map a one-hot row/column pair to the printed legend of the key.
  function automatic logic [CODE_W-1:0] key_code(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    logic [CODE_W-1:0] base;
    logic [CODE_W-1:0] off;
    case (col)
      3'b010:  off = 4'd1;
      3'b100:  off = 4'd2;
      default: off = 4'd0;
    endcase
    case (row)
      4'b0010: base = 4'd4;
      4'b0100: base = 4'd7;
      default: base = 4'd1;
    endcase
    if (row == 4'b1000) begin
      case (col)
        3'b001:  key_code = KEY_STAR;
        3'b010:  key_code = KEY_ZERO;
        default: key_code = KEY_HASH;
      endcase
    end else begin
      key_code = base + off;
    end
  endfunction

  function automatic logic [COL_W-1:0] col_rotate(input logic [COL_W-1:0] col);
    col_rotate = {col[COL_W-2:0], col[COL_W-1]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a registered one-clock pulse every DIV clocks.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= (cnt == LAST);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, row synchronizer, press/release
// debounce and single-event key reporting.
module keypad_scanner
  import game_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  key_row,
  output logic [COL_W-1:0]  key_col,
  output logic [CODE_W-1:0] key_data,
  output logic              key_valid,
  output logic              key_busy
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic [ROW_W-1:0]  row_meta;
  logic [ROW_W-1:0]  row_sync;
  logic              tick;

  scan_state_t       state, state_n;
  logic [ROW_W-1:0]  cand_row, cand_row_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [COL_W-1:0]  col_n;
  logic [CODE_W-1:0] data_n;
  logic              valid_n;
  logic              busy_n;

  logic              row_one_hot_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Row lines are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= key_row;
      row_sync <= row_meta;
    end
  end

  tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      cand_row  <= '0;
      cnt       <= '0;
      key_col   <= 3'b001;
      key_data  <= 4'h0;
      key_valid <= 1'b0;
      key_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      cand_row  <= cand_row_n;
      cnt       <= cnt_n;
      key_col   <= col_n;
      key_data  <= data_n;
      key_valid <= valid_n;
      key_busy  <= busy_n;
    end
  end

  assign row_one_hot_c = (row_sync != '0) && ((row_sync & (row_sync - 4'd1)) == '0);
  assign cnt_inc_c     = cnt + 4'd1;

  // cnt counts matching ticks in DEBOUNCE and all-zero ticks in HELD.
  always_comb begin
    state_n    = state;
    cand_row_n = cand_row;
    cnt_n      = cnt;
    col_n      = key_col;
    data_n     = key_data;
    valid_n    = 1'b0;
    busy_n     = key_busy;

    case (state)
      SCAN: begin
        if (tick) begin
          if (row_one_hot_c) begin
            cand_row_n = row_sync;
            cnt_n      = 4'd1;
            busy_n     = 1'b1;
            state_n    = DEBOUNCE;
          end else begin
            col_n = col_rotate(key_col);
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_sync == cand_row) begin
            cnt_n = cnt_inc_c;
            if (cnt_inc_c == DB_LAST) begin
              cnt_n   = '0;
              data_n  = key_code(cand_row, key_col);
              valid_n = 1'b1;
              state_n = HELD;
            end
          end else begin
            cnt_n   = '0;
            busy_n  = 1'b0;
            col_n   = col_rotate(key_col);
            state_n = SCAN;
          end
        end
      end
      HELD: begin
        if (tick) begin
          if (row_sync == '0) begin
            cnt_n = cnt_inc_c;
            if (cnt_inc_c == DB_LAST) begin
              cnt_n   = '0;
              busy_n  = 1'b0;
              col_n   = col_rotate(key_col);
              state_n = SCAN;
            end
          end else begin
            cnt_n = '0;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        busy_n  = 1'b0;
        col_n   = 3'b001;
        state_n = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix
// (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_busy;

  logic [3:0] pressed [3];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] ev_q [$];
  logic       prev_valid = 1'b0;
  int         double_valid = 0;
  logic [1:0] bc;
  logic       tref;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_busy  (key_busy)
  );

  always #5 clk = ~clk;

  // Pressed switches connect the driven column to their row lines.
  always_comb begin
    key_row = 4'b0000;
    if (key_col[0]) key_row = key_row | pressed[0];
    if (key_col[1]) key_row = key_row | pressed[1];
    if (key_col[2]) key_row = key_row | pressed[2];
  end

  always @(negedge clk) begin
    if (key_valid) ev_q.push_back(key_data);
    if (key_valid && prev_valid) double_valid++;
    prev_valid = key_valid;
  end

  // Scan-tick phase reference used only to align stimulus with scan ticks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc   <= 2'd0;
      tref <= 1'b0;
    end else begin
      bc   <= bc + 2'd1;
      tref <= (bc == 2'd3);
    end
  end

  // Returns 1 ns after the clock edge on which the scanner acts on a tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!tref) @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    pressed[0] = 4'b0; pressed[1] = 4'b0; pressed[2] = 4'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (key_col !== 3'b001) begin errors++; $display("FAIL reset_col got %b want 001", key_col); end
    checks++; if (key_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", key_data); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (key_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", key_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    pressed[1] = 4'b0010;
    wait_ticks(1);
    checks++; if (key_col !== 3'b010 || key_busy !== 1'b0) begin errors++; $display("FAIL k5_scan col=%b busy=%b want 010/0", key_col, key_busy); end
    wait_ticks(1);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL k5_detect busy got %b want 1", key_busy); end
    wait_ticks(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL k5_early valid got %b want 0", key_valid); end
    wait_ticks(1);
    checks++; if (key_valid !== 1'b1 || key_data !== 4'h5) begin errors++; $display("FAIL k5_event valid=%b data=%h want 1/5", key_valid, key_data); end
    wait_ticks(16);
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL k5_count got %0d want 1", ev_q.size()); end
    checks++; if (key_col !== 3'b010 || key_busy !== 1'b1) begin errors++; $display("FAIL k5_hold col=%b busy=%b want 010/1", key_col, key_busy); end
    pressed[1] = 4'b0;
    wait_ticks(2);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL k5_rel_early busy got %b want 1", key_busy); end
    wait_ticks(1);
    checks++; if (key_busy !== 1'b0 || key_col !== 3'b100) begin errors++; $display("FAIL k5_released busy=%b col=%b want 0/100", key_busy, key_col); end
  endtask

  task automatic test_bounce();
    int base;
    base = ev_q.size();
    for (int i = 0; i < 6; i++) begin
      pressed[0] = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      wait_ticks(1);
    end
    checks++; if (ev_q.size() != base || key_busy !== 1'b0) begin errors++; $display("FAIL bounce_quiet events=%0d busy=%b want %0d/0", ev_q.size(), key_busy, base); end
    pressed[0] = 4'b0001;
    wait_ticks(8);
    checks++; if (ev_q.size() != base + 1) begin errors++; $display("FAIL bounce_count got %0d want %0d", ev_q.size(), base + 1); end
    else begin
      checks++; if (ev_q[$] !== 4'h1) begin errors++; $display("FAIL bounce_data got %h want 1", ev_q[$]); end
    end
    pressed[0] = 4'b0;
    wait_ticks(4);
  endtask

  task automatic test_release();
    int base;
    base = ev_q.size();
    pressed[2] = 4'b0100;
    wait_ticks(8);
    checks++; if (ev_q.size() != base + 1 || key_data !== 4'h9) begin errors++; $display("FAIL k9_event count=%0d data=%h want %0d/9", ev_q.size(), key_data, base + 1); end
    pressed[2] = 4'b0;
    wait_ticks(2);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL rel_two busy got %b want 1", key_busy); end
    pressed[2] = 4'b0100;
    wait_ticks(1);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL rel_reassert busy got %b want 1", key_busy); end
    pressed[2] = 4'b0;
    wait_ticks(2);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL rel_partial busy got %b want 1", key_busy); end
    wait_ticks(1);
    checks++; if (key_busy !== 1'b0 || key_col !== 3'b001) begin errors++; $display("FAIL rel_done busy=%b col=%b want 0/001", key_busy, key_col); end
    checks++; if (ev_q.size() != base + 1) begin errors++; $display("FAIL rel_no_repeat got %0d want %0d", ev_q.size(), base + 1); end
  endtask

  task automatic test_multi_key();
    int base;
    logic [2:0] prev;
    base = ev_q.size();
    pressed[2] = 4'b0011;
    wait_ticks(1);
    prev = key_col;
    for (int i = 0; i < 3; i++) begin
      wait_ticks(1);
      checks++;
      if (key_col !== {prev[1:0], prev[2]} || key_busy !== 1'b0) begin
        errors++; $display("FAIL multi_rotate col=%b busy=%b want %b/0", key_col, key_busy, {prev[1:0], prev[2]});
      end
      prev = key_col;
    end
    wait_ticks(5);
    checks++; if (ev_q.size() != base) begin errors++; $display("FAIL multi_quiet got %0d want %0d", ev_q.size(), base); end
    pressed[2] = 4'b1000;
    wait_ticks(8);
    checks++; if (ev_q.size() != base + 1 || key_data !== 4'hB) begin errors++; $display("FAIL hash_event count=%0d data=%h want %0d/b", ev_q.size(), key_data, base + 1); end
    pressed[2] = 4'b0;
    wait_ticks(4);
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    base = ev_q.size();
    seen = 1'b0;
    pressed[1] = 4'b0001;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (key_busy) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_detect busy got 0 want 1 within 60 cycles"); end
    wait_ticks(1);
    checks++; if (key_busy !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL mid_state busy=%b valid=%b want 1/0", key_busy, key_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key_col !== 3'b001 || key_busy !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL mid_async col=%b busy=%b valid=%b want 001/0/0", key_col, key_busy, key_valid); end
    pressed[1] = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(8);
    checks++; if (ev_q.size() != base || key_busy !== 1'b0) begin errors++; $display("FAIL mid_no_event count=%0d busy=%b want %0d/0", ev_q.size(), key_busy, base); end
  endtask

  task automatic test_handover();
    int base;
    base = ev_q.size();
    pressed[0] = 4'b0100;
    wait_ticks(8);
    checks++; if (ev_q.size() != base + 1) begin errors++; $display("FAIL hand_first count got %0d want %0d", ev_q.size(), base + 1); end
    pressed[2] = 4'b0001;
    wait_ticks(6);
    checks++; if (ev_q.size() != base + 1 || key_col !== 3'b001 || key_busy !== 1'b1) begin errors++; $display("FAIL hand_ignored count=%0d col=%b busy=%b want %0d/001/1", ev_q.size(), key_col, key_busy, base + 1); end
    pressed[0] = 4'b0;
    wait_ticks(12);
    checks++; if (ev_q.size() != base + 2) begin errors++; $display("FAIL hand_count got %0d want %0d", ev_q.size(), base + 2); end
    else begin
      checks++; if (ev_q[base] !== 4'h7 || ev_q[base + 1] !== 4'h3) begin errors++; $display("FAIL hand_order got %h,%h want 7,3", ev_q[base], ev_q[base + 1]); end
    end
    pressed[2] = 4'b0;
    wait_ticks(4);
    checks++; if (double_valid != 0) begin errors++; $display("FAIL valid_width got %0d long strobes want 0", double_valid); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_multi_key();
    test_reset_mid();
    test_handover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
